// File: rtl/sdf_twiddle_mul_pkg.sv
// Shared constants and the Q1.15 round/saturate helper for the R2SDF twiddle-multiply stage.
package sdf_twiddle_mul_pkg;

  localparam int WIDTH      = 16;
  localparam int LOG2N      = 4;
  localparam int FFT_POINTS = 1 << LOG2N;

  localparam logic signed [2*WIDTH:0] ROUND_BIAS = (2*WIDTH+1)'(2 ** (WIDTH-2));
  localparam logic signed [WIDTH+1:0] SAT_MAX    = (WIDTH+2)'(2 ** (WIDTH-1) - 1);
  localparam logic signed [WIDTH+1:0] SAT_MIN    = (WIDTH+2)'(-(2 ** (WIDTH-1)));

  // Round half up, drop WIDTH-1 fraction bits, clip to the WIDTH-bit signed range.
  function automatic logic [WIDTH-1:0] round_sat(input logic signed [2*WIDTH:0] x);
    logic signed [2*WIDTH:0] biased;
    logic signed [WIDTH+1:0] q;
    biased = x + ROUND_BIAS;
    q      = biased[2*WIDTH -: WIDTH+2];
    if (q > SAT_MAX)      round_sat = SAT_MAX[WIDTH-1:0];
    else if (q < SAT_MIN) round_sat = SAT_MIN[WIDTH-1:0];
    else                  round_sat = q[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/sdf_twiddle_mul_twiddle_rom.sv
// N-entry twiddle table W_N^addr = cos - j*sin in Q1.15, registered output (1-cycle latency).
module twiddle_rom
  import sdf_twiddle_mul_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LOG2N-1:0]     addr,
  output logic [WIDTH-1:0]     tw_re,
  output logic [WIDTH-1:0]     tw_im
);

  // {re, im}; +1 is stored as 0x7FFF, while an exact -1 is representable as 0x8000.
  localparam logic [2*WIDTH-1:0] TABLE [FFT_POINTS] = '{
    {16'h7FFF, 16'h0000}, {16'h7641, 16'hCF05}, {16'h5A82, 16'hA57E}, {16'h30FB, 16'h89BF},
    {16'h0000, 16'h8000}, {16'hCF05, 16'h89BF}, {16'hA57E, 16'hA57E}, {16'h89BF, 16'hCF05},
    {16'h8000, 16'h0000}, {16'h89BF, 16'h30FB}, {16'hA57E, 16'h5A82}, {16'hCF05, 16'h7641},
    {16'h0000, 16'h7FFF}, {16'h30FB, 16'h7641}, {16'h5A82, 16'h5A82}, {16'h7641, 16'h30FB}
  };

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tw_re <= '0;
      tw_im <= '0;
    end else begin
      tw_re <= TABLE[addr][2*WIDTH-1:WIDTH];
      tw_im <= TABLE[addr][WIDTH-1:0];
    end
  end

endmodule

// File: rtl/sdf_twiddle_mul.sv
// R2SDF twiddle-multiply stage: counter-driven twiddle address, 3-cycle pipelined complex multiply.
module sdf_twiddle_mul #(
  parameter int WIDTH = sdf_twiddle_mul_pkg::WIDTH,
  parameter int LOG2N = sdf_twiddle_mul_pkg::LOG2N,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im
);
  import sdf_twiddle_mul_pkg::*;

  localparam int CW = LOG2N - STAGE;

  logic [CW-1:0]             cnt;
  logic [LOG2N-1:0]          addr;
  logic signed [WIDTH-1:0]   tw_re, tw_im;

  logic                      s1_en, s1_byp;
  logic signed [WIDTH-1:0]   s1_re, s1_im;
  logic                      s2_en, s2_byp;
  logic [WIDTH-1:0]          s2_re, s2_im;
  logic signed [2*WIDTH-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [2*WIDTH:0]   sum_re, sum_im;

  // Second half of each block gets W^(k<<STAGE); first half is the sum half (addr 0).
  always_comb begin
    addr = '0;
    if (cnt[CW-1]) addr = LOG2N'(cnt[CW-2:0]) << STAGE;
  end

  // ROM addressed combinationally so its registered output lines up with the C1 data.
  twiddle_rom u_rom (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .tw_re (tw_re),
    .tw_im (tw_im)
  );

  always_comb begin
    sum_re = (2*WIDTH+1)'(p_rr) - (2*WIDTH+1)'(p_ii);
    sum_im = (2*WIDTH+1)'(p_ri) + (2*WIDTH+1)'(p_ir);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      s1_en  <= 1'b0;
      s1_byp <= 1'b0;
      s1_re  <= '0;
      s1_im  <= '0;
      s2_en  <= 1'b0;
      s2_byp <= 1'b0;
      s2_re  <= '0;
      s2_im  <= '0;
      p_rr   <= '0;
      p_ii   <= '0;
      p_ri   <= '0;
      p_ir   <= '0;
      do_en  <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
    end else begin
      // C1: capture sample and bypass decision
      s1_en <= di_en;
      if (di_en) begin
        cnt    <= cnt + 1'b1;
        s1_re  <= di_re;
        s1_im  <= di_im;
        s1_byp <= (addr == '0);
      end
      // C2: products against the now-valid twiddle
      s2_en  <= s1_en;
      s2_byp <= s1_byp;
      s2_re  <= s1_re;
      s2_im  <= s1_im;
      p_rr   <= (2*WIDTH)'(s1_re) * (2*WIDTH)'(tw_re);
      p_ii   <= (2*WIDTH)'(s1_im) * (2*WIDTH)'(tw_im);
      p_ri   <= (2*WIDTH)'(s1_re) * (2*WIDTH)'(tw_im);
      p_ir   <= (2*WIDTH)'(s1_im) * (2*WIDTH)'(tw_re);
      // C3: round/saturate, or pass through exactly when the twiddle is 1
      do_en <= s2_en;
      if (s2_en) begin
        do_re <= s2_byp ? s2_re : round_sat(sum_re);
        do_im <= s2_byp ? s2_im : round_sat(sum_im);
      end
    end
  end

endmodule

// File: tb/tb_sdf_twiddle_mul.sv
// Directed and randomised checks of sdf_twiddle_mul for STAGE 0, 1 and 2 (N=16).
module tb_sdf_twiddle_mul;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        di_en;
  logic [15:0] di_re, di_im;
  logic        o_en [3];
  logic [15:0] o_re [3];
  logic [15:0] o_im [3];

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // expected-output delay line, index 3 = the drive whose result is visible now
  logic        pe_en [4];
  logic [15:0] pe_re [4];
  logic [15:0] pe_im [4];

  always #5 clk = ~clk;

  sdf_twiddle_mul #(.WIDTH(16), .LOG2N(4), .STAGE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(o_en[0]), .do_re(o_re[0]), .do_im(o_im[0]));
  sdf_twiddle_mul #(.WIDTH(16), .LOG2N(4), .STAGE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(o_en[1]), .do_re(o_re[1]), .do_im(o_im[1]));
  sdf_twiddle_mul #(.WIDTH(16), .LOG2N(4), .STAGE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .di_en(di_en), .di_re(di_re), .di_im(di_im),
    .do_en(o_en[2]), .do_re(o_re[2]), .do_im(o_im[2]));

  // STAGE 0 outputs for 16 samples of (0x4000, 0)
  localparam logic [15:0] E1RE [16] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000,
                                        16'h4000, 16'h4000, 16'h4000, 16'h4000,
                                        16'h4000, 16'h3B21, 16'h2D41, 16'h187E,
                                        16'h0000, 16'hE783, 16'hD2BF, 16'hC4E0};
  localparam logic [15:0] E1IM [16] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                        16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                        16'h0000, 16'hE783, 16'hD2BF, 16'hC4E0,
                                        16'hC000, 16'hC4E0, 16'hD2BF, 16'hE783};
  // STAGE 1 outputs for 8 samples of (0x4000, 0)
  localparam logic [15:0] E5RE [8] = '{16'h4000, 16'h4000, 16'h4000, 16'h4000,
                                       16'h4000, 16'h2D41, 16'h0000, 16'hD2BF};
  localparam logic [15:0] E5IM [8] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                       16'h0000, 16'hD2BF, 16'hC000, 16'hD2BF};
  // reference twiddles for addresses 0..N/2-1
  localparam logic [15:0] TWR [8] = '{16'h7FFF, 16'h7641, 16'h5A82, 16'h30FB,
                                      16'h0000, 16'hCF05, 16'hA57E, 16'h89BF};
  localparam logic [15:0] TWI [8] = '{16'h0000, 16'hCF05, 16'hA57E, 16'h89BF,
                                      16'h8000, 16'h89BF, 16'hA57E, 16'hCF05};

  typedef struct packed {
    logic [15:0] r0, i0, r1, i1, r2, i2;
  } exp_t;
  exp_t exq[$];

  task automatic clear_pipe();
    for (int i = 0; i < 4; i++) begin
      pe_en[i] = 1'b0; pe_re[i] = '0; pe_im[i] = '0;
    end
  endtask

  task automatic advance(input logic en, input logic [15:0] re, input logic [15:0] im,
                         input logic xen, input logic [15:0] xre, input logic [15:0] xim);
    @(negedge clk);
    for (int i = 3; i > 0; i--) begin
      pe_en[i] = pe_en[i-1]; pe_re[i] = pe_re[i-1]; pe_im[i] = pe_im[i-1];
    end
    pe_en[0] = xen; pe_re[0] = xre; pe_im[0] = xim;
    di_en = en; di_re = re; di_im = im;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; di_en = 1'b0; di_re = '0; di_im = '0;
    clear_pipe();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [15:0] sat16(input longint p);
    longint q;
    q = (p + 64'sd16384) >>> 15;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return q[15:0];
  endfunction

  function automatic logic [31:0] model(input logic [15:0] re, input logic [15:0] im, input int addr);
    longint ar, ai, wr, wi;
    if (addr == 0) return {re, im};
    ar = longint'($signed(re));      ai = longint'($signed(im));
    wr = longint'($signed(TWR[addr])); wi = longint'($signed(TWI[addr]));
    return {sat16(ar * wr - ai * wi), sat16(ar * wi + ai * wr)};
  endfunction

  task automatic test_reset();
    for (int s = 0; s < 3; s++) begin
      vectors++;
      if (o_en[s] !== 1'b0) begin errors++; $display("FAIL reset_en[%0d]: got %b want 0", s, o_en[s]); end
      vectors++;
      if (o_re[s] !== 16'h0000) begin errors++; $display("FAIL reset_re[%0d]: got %h want 0000", s, o_re[s]); end
      vectors++;
      if (o_im[s] !== 16'h0000) begin errors++; $display("FAIL reset_im[%0d]: got %h want 0000", s, o_im[s]); end
    end
  endtask

  task automatic test_contiguous();
    do_reset();
    for (int c = 0; c < 19; c++) begin
      advance(c < 16, 16'h4000, 16'h0000, c < 16, E1RE[c % 16], E1IM[c % 16]);
      vectors++;
      if (o_en[0] !== pe_en[3]) begin errors++; $display("FAIL contig_en c%0d: got %b want %b", c, o_en[0], pe_en[3]); end
      if (pe_en[3]) begin
        vectors++;
        if (o_re[0] !== pe_re[3] || o_im[0] !== pe_im[3]) begin
          errors++;
          $display("FAIL contig_data c%0d: got %h/%h want %h/%h", c, o_re[0], o_im[0], pe_re[3], pe_im[3]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic [15:0] xr, xi, ir, ii;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      ir = (c == 10) ? 16'h7FFF : 16'h0000;
      ii = (c == 10) ? 16'h8000 : 16'h0000;
      xr = (c == 10) ? 16'hFFFF : 16'h0000;
      xi = (c == 10) ? 16'h8000 : 16'h0000;
      advance(c < 11, ir, ii, c < 11, xr, xi);
      vectors++;
      if (o_en[0] !== pe_en[3]) begin errors++; $display("FAIL sat_en c%0d: got %b want %b", c, o_en[0], pe_en[3]); end
      if (pe_en[3]) begin
        vectors++;
        if (o_re[0] !== pe_re[3] || o_im[0] !== pe_im[3]) begin
          errors++;
          $display("FAIL sat_data c%0d: got %h/%h want %h/%h", c, o_re[0], o_im[0], pe_re[3], pe_im[3]);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [15:0] last_re, last_im;
    logic        en;
    int          s;
    last_re = '0; last_im = '0;
    do_reset();
    for (int c = 0; c < 51; c++) begin
      en = (c % 3 == 0) && (c < 48);
      s  = c / 3;
      advance(en, 16'h4000, 16'h0000, en, E1RE[s % 16], E1IM[s % 16]);
      vectors++;
      if (o_en[0] !== pe_en[3]) begin errors++; $display("FAIL gap_en c%0d: got %b want %b", c, o_en[0], pe_en[3]); end
      if (pe_en[3]) begin
        last_re = pe_re[3]; last_im = pe_im[3];
      end
      vectors++;
      if (o_re[0] !== last_re || o_im[0] !== last_im) begin
        errors++;
        $display("FAIL gap_data c%0d: got %h/%h want %h/%h", c, o_re[0], o_im[0], last_re, last_im);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      advance(1'b1, 16'h4000, 16'h0000, 1'b1, E1RE[c], E1IM[c]);
      vectors++;
      if (o_en[0] !== pe_en[3]) begin errors++; $display("FAIL mid_en c%0d: got %b want %b", c, o_en[0], pe_en[3]); end
    end
    // reset wins over a sample presented in the same cycle
    @(negedge clk);
    rst_n = 1'b0; di_en = 1'b1; di_re = 16'h1111; di_im = 16'h2222;
    clear_pipe();
    @(negedge clk);
    rst_n = 1'b1; di_en = 1'b0;
    vectors++;
    if (o_en[0] !== 1'b0 || o_re[0] !== 16'h0000 || o_im[0] !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_out: got %b %h/%h want 0 0000/0000", o_en[0], o_re[0], o_im[0]);
    end
    for (int c = 0; c < 6; c++) begin
      advance(c == 2, 16'h1234, 16'h5678, c == 2, 16'h1234, 16'h5678);
      vectors++;
      if (o_en[0] !== pe_en[3]) begin errors++; $display("FAIL mid_after_en c%0d: got %b want %b", c, o_en[0], pe_en[3]); end
      if (pe_en[3]) begin
        vectors++;
        if (o_re[0] !== 16'h1234 || o_im[0] !== 16'h5678) begin
          errors++;
          $display("FAIL mid_bypass: got %h/%h want 1234/5678", o_re[0], o_im[0]);
        end
      end
    end
  endtask

  task automatic test_stage1();
    do_reset();
    for (int c = 0; c < 11; c++) begin
      advance(c < 8, 16'h4000, 16'h0000, c < 8, E5RE[c % 8], E5IM[c % 8]);
      vectors++;
      if (o_en[1] !== pe_en[3]) begin errors++; $display("FAIL stage1_en c%0d: got %b want %b", c, o_en[1], pe_en[3]); end
      if (pe_en[3]) begin
        vectors++;
        if (o_re[1] !== pe_re[3] || o_im[1] !== pe_im[3]) begin
          errors++;
          $display("FAIL stage1_data c%0d: got %h/%h want %h/%h", c, o_re[1], o_im[1], pe_re[3], pe_im[3]);
        end
      end
    end
  endtask

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic test_random();
    int          mcnt [3];
    int          m, addr, samples;
    logic        en;
    logic [15:0] r, i;
    logic [31:0] res [3];
    exp_t        e;
    logic [15:0] got_r, got_i, want_r, want_i;
    do_reset();
    exq.delete();
    for (int s = 0; s < 3; s++) mcnt[s] = 0;
    samples = 0;
    for (int c = 0; c < 20000; c++) begin
      en = (samples < 10000) && ($urandom_range(0, 9) < 7);
      r = pick16(); i = pick16();
      if (en) begin
        samples++;
        for (int s = 0; s < 3; s++) begin
          m    = 16 >> s;
          addr = (mcnt[s] >= m / 2) ? ((mcnt[s] - m / 2) << s) : 0;
          res[s]  = model(r, i, addr);
          mcnt[s] = (mcnt[s] + 1) % m;
        end
        exq.push_back({res[0], res[1], res[2]});
      end
      advance(en, r, i, en, 16'h0000, 16'h0000);
      if (exq.size() == 0 && !pe_en[3] && samples >= 10000) break;
      for (int s = 0; s < 3; s++) begin
        vectors++;
        if (o_en[s] !== pe_en[3]) begin errors++; $display("FAIL rand_en[%0d] c%0d: got %b want %b", s, c, o_en[s], pe_en[3]); end
      end
      if (pe_en[3]) begin
        if (exq.size() == 0) begin
          errors++; vectors++;
          $display("FAIL rand_queue c%0d: got empty want entry", c);
        end else begin
          e = exq.pop_front();
          for (int s = 0; s < 3; s++) begin
            got_r  = o_re[s]; got_i = o_im[s];
            want_r = (s == 0) ? e.r0 : (s == 1) ? e.r1 : e.r2;
            want_i = (s == 0) ? e.i0 : (s == 1) ? e.i1 : e.i2;
            vectors++;
            if (got_r !== want_r || got_i !== want_i) begin
              errors++;
              $display("FAIL rand_data[%0d] c%0d: got %h/%h want %h/%h", s, c, got_r, got_i, want_r, want_i);
            end
          end
        end
      end
    end
    vectors++;
    if (exq.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d pending want 0", exq.size()); end
  endtask

  initial begin
    rst_n = 1'b0; di_en = 1'b0; di_re = '0; di_im = '0;
    clear_pipe();
    repeat (3) @(negedge clk);
    test_reset();
    test_contiguous();
    test_saturation();
    test_gaps();
    test_reset_midframe();
    test_stage1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
